// File: rtl/sha256_pkg.sv
// sha256_pkg: constants, FSM state encoding and small-sigma helpers shared by
// the SHA-256 message-schedule expander and, later, the compression core.
package sha256_pkg;

    localparam int WORD_W   = 32;  // fixed by SHA-256
    localparam int W_LENGTH = 64;  // schedule words per block
    localparam int WIN_LEN  = 16;  // sliding-window depth
    localparam int IDX_W    = $clog2(W_LENGTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [WORD_W-1:0] s0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [WORD_W-1:0] s1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_w_next.sv
// sha256_w_next: combinational next-schedule-word generator.
// Ports:
//   w0, w1, w9, w14 : window taps win[0], win[1], win[9], win[14]
//   w_next          : s1(w14) + w9 + s0(w1) + w0, mod 2^32
module sha256_w_next
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] w0,
    input  logic [WORD_W-1:0] w1,
    input  logic [WORD_W-1:0] w9,
    input  logic [WORD_W-1:0] w14,
    output logic [WORD_W-1:0] w_next
);

    // Sum truncates to WORD_W bits, giving the mod-2^32 wrap.
    assign w_next = s1(w14) + w9 + s0(w1) + w0;

endmodule

// File: rtl/sha256_w_expand.sv
// sha256_w_expand: SHA-256 message-schedule expander. Loads one 512-bit block
// and streams W0..W63 through a 16-word sliding window.
// Ports:
//   clock, reset      : rising-edge clock, async active-low reset
//   start, block_in   : load request (taken only while ready) and block,
//                       block_in[511:480] = W0 ... block_in[31:0] = W15
//   ready             : idle, a block may be loaded
//   w_valid, w_ready  : output handshake for w_out / w_index
//   w_out, w_index    : schedule word W[t] and its index t
//   done              : one-cycle pulse after W63 is accepted
module sha256_w_expand
    import sha256_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [511:0]       block_in,
    output logic               ready,
    output logic               w_valid,
    input  logic               w_ready,
    output logic [WORD_W-1:0]  w_out,
    output logic [IDX_W-1:0]   w_index,
    output logic               done
);

    localparam logic [IDX_W-1:0] T_LAST = IDX_W'(W_LENGTH - 1);

    state_e                           state_q, state_d;
    logic [IDX_W-1:0]                 t_q, t_d;
    logic [WIN_LEN-1:0][WORD_W-1:0]   win_q, win_d;  // win_q[0] is W[t]
    logic [WORD_W-1:0]                w_next;

    sha256_w_next u_w_next (
        .w0     (win_q[0]),
        .w1     (win_q[1]),
        .w9     (win_q[9]),
        .w14    (win_q[14]),
        .w_next (w_next)
    );

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        win_d   = win_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int k = 0; k < WIN_LEN; k++)
                        win_d[k] = block_in[WORD_W*(WIN_LEN-1-k) +: WORD_W];
                    t_d     = '0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_ready) begin
                    if (t_q == T_LAST) begin
                        // Last word gone; the window is no longer needed.
                        state_d = ST_DONE;
                    end else begin
                        win_d[WIN_LEN-2:0] = win_q[WIN_LEN-1:1];
                        win_d[WIN_LEN-1]   = w_next;
                        t_d                = t_q + 1'b1;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            win_q   <= win_d;
        end
    end

    // Status outputs decode straight from the state flop, so they are glitch
    // free and drop in the same cycle reset is asserted.
    assign ready   = (state_q == ST_IDLE);
    assign w_valid = (state_q == ST_STREAM);
    assign done    = (state_q == ST_DONE);
    assign w_out   = win_q[0];
    assign w_index = t_q;

endmodule

// File: tb/tb_sha256_w_expand.sv
module tb_sha256_w_expand;

    logic         clock    = 1'b0;
    logic         reset    = 1'b0;
    logic         start    = 1'b0;
    logic [511:0] block_in = '0;
    logic         w_ready  = 1'b0;
    logic         ready, w_valid, done;
    logic [31:0]  w_out;
    logic [5:0]   w_index;

    sha256_w_expand dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .block_in (block_in),
        .ready    (ready),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_out    (w_out),
        .w_index  (w_index),
        .done     (done)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(negedge clock) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model: full 64-word schedule ----------------
    typedef struct { int idx; logic [31:0] w; } exp_t;
    exp_t q[$];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] sg0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] sg1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic void push_block(input logic [511:0] b);
        logic [31:0] w [64];
        exp_t e;
        for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = sg1(w[t-2]) + w[t-7] + sg0(w[t-15]) + w[t-16];
        for (int t = 0; t < 64; t++) begin
            e.idx = t;
            e.w   = w[t];
            q.push_back(e);
        end
    endfunction

    function automatic logic [511:0] rblk();
        logic [511:0] b;
        for (int k = 0; k < 16; k++) b[32*k +: 32] = $urandom;
        return b;
    endfunction

    // ---------------- w_ready driver ----------------
    int mode       = 0;   // 0: always ready, 1: random with forced stalls
    int stall_left = 0;
    int last_idx   = -1;
    always @(posedge clock) begin
        #1;
        if (mode == 1 && w_valid && int'(w_index) != last_idx &&
            (w_index == 6'd15 || w_index == 6'd16))
            stall_left = 10;
        last_idx = w_valid ? int'(w_index) : -1;
        if (stall_left > 0) begin
            w_ready = 1'b0;
            stall_left--;
        end else begin
            w_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [31:0] obs [64];
    bit          done_exp = 0;
    bit          held     = 0;
    logic [31:0] hw;
    logic [5:0]  hi;

    always @(negedge clock) begin
        if (!reset) begin
            done_exp = 0;
            held     = 0;
        end else begin
            chk("done", done, done_exp);
            done_exp = 0;
            if (held) begin
                chk("stall_w_valid", w_valid, 1);
                chk("stall_w_out", w_out, hw);
                chk("stall_w_index", w_index, hi);
            end
            held = 0;
            if (w_valid) begin
                if (w_ready) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_word: got index %0d, none expected", w_index);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("w_index", w_index, e.idx);
                        chk("w_out", w_out, e.w);
                    end
                    obs[w_index] = w_out;
                    if (w_index == 6'd63) done_exp = 1;
                end else begin
                    held = 1;
                    hw   = w_out;
                    hi   = w_index;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 500) begin
            tick();
            n++;
        end
        if (!ready) chk("ready_timeout", ready, 1);
    endtask

    task automatic load(input logic [511:0] b, output int lc);
        wait_ready();
        start    = 1'b1;
        block_in = b;
        push_block(b);
        tick();
        lc       = cyc;
        start    = 1'b0;
        block_in = rblk();
        chk("load_latency_valid", w_valid, 1);
        chk("load_latency_index", w_index, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || !ready) && n < 3000) begin
            tick();
            n++;
        end
        if (q.size() != 0 || !ready) chk("drain_timeout", q.size(), 0);
    endtask

    task automatic wait_index(input int idx);
        int n = 0;
        while (!(w_valid && int'(w_index) == idx) && n < 500) begin
            tick();
            n++;
        end
        if (!(w_valid && int'(w_index) == idx)) chk("index_timeout", w_index, idx);
    endtask

    logic [511:0] abc;
    int c1, c2;

    initial begin
        abc            = '0;
        abc[511:480]   = 32'h61626380;
        abc[31:0]      = 32'h00000018;

        // reset state
        #3;
        chk("rst_ready", ready, 1);
        chk("rst_w_valid", w_valid, 0);
        chk("rst_w_out", w_out, 0);
        chk("rst_w_index", w_index, 0);
        chk("rst_done", done, 0);
        tick();
        reset = 1'b1;
        tick();

        // FIPS "abc" block, full throughput
        mode = 0;
        load(abc, c1);
        drain();
        chk("abc_w0", obs[0], 32'h61626380);
        chk("abc_w15", obs[15], 32'h00000018);
        chk("abc_w16", obs[16], 32'h61626380);
        chk("abc_w17", obs[17], 32'h000F0000);
        chk("abc_w18", obs[18], 32'h7DA86405);
        chk("abc_w19", obs[19], 32'h600003C6);

        // same block with random back-pressure and long stalls at t=15/16
        mode = 1;
        load(abc, c1);
        drain();

        // start re-pulsed mid-stream must be ignored
        mode = 0;
        load(abc, c1);
        wait_index(30);
        start    = 1'b1;
        block_in = rblk();
        chk("busy_ready", ready, 0);
        tick();
        start = 1'b0;
        drain();

        // reset mid-stream
        load(rblk(), c1);
        wait_index(40);
        reset = 1'b0;
        #1;
        chk("midrst_w_valid", w_valid, 0);
        chk("midrst_ready", ready, 1);
        chk("midrst_w_index", w_index, 0);
        chk("midrst_done", done, 0);
        q.delete();
        tick();
        reset = 1'b1;
        tick();
        load(rblk(), c1);
        drain();

        // back-to-back loads at the earliest legal cycle
        load(abc, c1);
        load(rblk(), c2);
        chk("b2b_period", c2 - c1, 66);
        drain();

        // all-ones block exercises mod 2^32 wrap
        mode = 1;
        load({512{1'b1}}, c1);
        drain();

        // a few random blocks under random back-pressure
        for (int i = 0; i < 3; i++) begin
            load(rblk(), c1);
            drain();
        end

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_w_expand.md
Name: sha256_w_expand

Overview:
- Message-schedule expander that sits directly downstream of the 512-bit block loader.
- Accepts one 512-bit padded message block and streams W0..W63 one 32-bit word per accepted beat to the compression-round core.
- Uses a 16-word sliding window, so no 2048-bit schedule vector is stored.
- Valid/ready handshake on the output side; start/ready handshake on the input side.

Parameters:
- W_LENGTH, 64, number of schedule words emitted per block.
- WORD_W, 32, word width in bits; fixed by SHA-256, not intended to be overridden.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- start  input  1  load request; sampled only while ready=1.
- block_in  input  512  padded message block; block_in[511:480]=W0, block_in[31:0]=W15 (big-endian word order).
- ready  output  1  high in IDLE; block may be loaded.
- w_valid  output  1  w_out/w_index hold a valid schedule word.
- w_ready  input  1  downstream accepts the word this cycle.
- w_out  output  32  current schedule word W[w_index].
- w_index  output  $clog2(W_LENGTH)  index t of w_out, 0..63.
- done  output  1  one-cycle pulse after W63 is accepted.

Behaviour:
- Reset (reset=0, async): state=IDLE, window cleared, t=0, ready=1, w_valid=0, w_out=0, w_index=0, done=0.
- States are IDLE, STREAM and DONE.
- IDLE:
  - ready=1, w_valid=0.
  - start=1 at a clock edge latches win[k]=block_in[511-32k -: 32] for k=0..15, sets t=0 and moves to STREAM.
  - Load latency: w_valid rises the cycle after start.
- STREAM:
  - w_valid=1, w_out=win[0], w_index=t, ready=0.
  - Accept means w_valid & w_ready at a clock edge. On accept:
    - shift the window (win[k]<=win[k+1], k=0..14);
    - win[15] <= s1(win[14]) + win[9] + s0(win[1]) + win[0], mod 2^32 (carries above bit 31 discarded);
    - t <= t+1.
  - s0(x) = ROTR7 ^ ROTR18 ^ SHR3; s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - Stall: with w_ready=0, window, t, w_out and w_index hold unchanged for any number of cycles. w_valid must not drop once asserted until the word is accepted.
  - Accept at t=W_LENGTH-1 moves to DONE; no further window update is needed.
  - Throughput: one word per cycle with w_ready held high, so 64 beats in 64 consecutive cycles.
- DONE: w_valid=0, done=1 for exactly one cycle, then IDLE with ready=1.
- Earliest back-to-back load: start may be applied the cycle ready returns. Load-to-load period is 66 cycles minimum (1 load + 64 stream + 1 done).
- start while not IDLE: ignored; an in-flight block is never disturbed. block_in is don't-care outside the load edge.
- Reset mid-STREAM or mid-DONE: immediate return to reset values. A partially streamed block is discarded and done is not pulsed.
- w_index never wraps; t=W_LENGTH is unreachable in STREAM.
- Words t<16 are passed through unmodified from block_in.

Decomposition:
- Package sha256_pkg holds:
  - WORD_W=32 and W_LENGTH=64;
  - the state encoding (IDLE, STREAM, DONE);
  - small-sigma functions s0 and s1, shared later with the compression core's big-sigma set.
- One natural sub-module: sha256_w_next, purely combinational. It takes win[0], win[1], win[9] and win[14] and returns the next 32-bit word. The top holds the FSM, counter and window registers.

Test Plan:
- FIPS "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), start, w_ready=1 -> w_out for t=0..19 is:
  - t=0..15 equal to the input words;
  - W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6;
  - all 64 words match the golden model; done pulses the cycle after W63 is accepted.
- Same block with w_ready toggled pseudo-randomly (including 10-cycle stalls at t=15 and t=16) -> identical 64-word sequence; w_out and w_index stable throughout each stall.
- start re-pulsed with a different block_in at t=30 -> ignored; output continues the original block sequence.
- reset asserted at t=40 -> same cycle: w_valid=0, ready=1, w_index=0; no done. A new start afterwards streams the new block from W0.
- Back-to-back: start on the cycle ready rises after done -> second block W0 appears the next cycle; 66-cycle period confirmed.
- All-ones block -> arithmetic wraps mod 2^32 and matches the golden model for W16..W63.
